// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Serves word loads/stores from EX/MEM and refills 256-bit lines over a req/ack memory port.
module dcache_controller #(
    parameter int LINES  = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_memread_i,
    input  logic              cpu_memwrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - IDX_W - 5;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [LINE_W-1:0] lines [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        word_sel;
    logic [7:0]        bit_base;
    logic              access;
    logic              hit;
    logic              unused_addr_bits;

    assign idx              = cpu_addr_i[5 +: IDX_W];
    assign tag              = cpu_addr_i[31 -: TAG_W];
    assign word_sel         = cpu_addr_i[4:2];
    assign bit_base         = {word_sel, 5'b0};
    assign access           = cpu_memread_i | cpu_memwrite_i;
    assign hit              = valid[idx] && (tags[idx] == tag);
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // A load with memwrite also high is a store, so it never returns data.
    always_comb begin
        cpu_data_o  = 32'h0;
        cpu_stall_o = 1'b0;
        if (state != IDLE) begin
            cpu_stall_o = 1'b1;
        end else if (access && !hit) begin
            cpu_stall_o = 1'b1;
        end else if (cpu_memread_i && !cpu_memwrite_i && hit) begin
            cpu_data_o = lines[idx][bit_base +: 32];
        end
    end

    // The CPU holds its request stable while stalled, so idx/tag stay valid
    // across the whole miss sequence without being latched here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= 32'h0;
            mem_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            if (cpu_memwrite_i) begin
                                lines[idx][bit_base +: 32] <= cpu_data_i;
                                dirty[idx]                 <= 1'b1;
                            end
                        end else if (valid[idx] && dirty[idx]) begin
                            state      <= WRITEBACK;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= {tags[idx], idx, 5'b0};
                            mem_data_o <= lines[idx];
                        end else begin
                            state      <= ALLOCATE;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {tag, idx, 5'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state      <= ALLOCATE;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {tag, idx, 5'b0};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        lines[idx] <= mem_data_i;
                        tags[idx]  <= tag;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: refills, hits, write-back,
// back-to-back acks, stray acks and reset during a miss.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_memread_i;
    logic         cpu_memwrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks   = 0;
    int failures = 0;

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_memread_i  (cpu_memread_i),
        .cpu_memwrite_i (cpu_memwrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        cpu_memread_i  = rd;
        cpu_memwrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs,
                               input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line whose word k is base+k, except word 0 which is w0.
    function automatic logic [255:0] makeLine(input logic [31:0] base, input logic [31:0] w0);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        l[31:0] = w0;
        return l;
    endfunction

    initial begin
        logic [255:0] wb_line;

        rst_i      = 1'b1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checkOutput("rst_req",   {255'b0, mem_req_o},  256'd0);
        checkOutput("rst_we",    {255'b0, mem_we_o},   256'd0);
        checkOutput("rst_addr",  {224'b0, mem_addr_o}, 256'd0);
        checkOutput("rst_mdata", mem_data_o,           256'd0);
        checkOutput("rst_data",  {224'b0, cpu_data_o}, 256'd0);
        checkOutput("rst_stall", {255'b0, cpu_stall_o}, 256'd0);

        // No access while the address wanders.
        applyStimulus(1'b0, 1'b0, 32'h0000_0123, 32'hFFFF_FFFF);
        checkOutput("noacc_stall0", {255'b0, cpu_stall_o}, 256'd0);
        checkOutput("noacc_data0",  {224'b0, cpu_data_o},  256'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0000_0044, 32'h0);
        checkOutput("noacc_req", {255'b0, mem_req_o},   256'd0);
        checkOutput("noacc_stall1", {255'b0, cpu_stall_o}, 256'd0);

        // Clean miss at 0x40, ack after 10 cycles.
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("miss_stall_c0", {255'b0, cpu_stall_o}, 256'd1);
        checkOutput("miss_data_c0",  {224'b0, cpu_data_o},  256'd0);
        tick();
        checkOutput("fetch_req",  {255'b0, mem_req_o},   256'd1);
        checkOutput("fetch_we",   {255'b0, mem_we_o},    256'd0);
        checkOutput("fetch_addr", {224'b0, mem_addr_o},  256'h40);
        for (int c = 2; c <= 10; c++) tick();
        checkOutput("fetch_stall_c10", {255'b0, cpu_stall_o}, 256'd1);
        checkOutput("fetch_req_c10",   {255'b0, mem_req_o},   256'd1);
        mem_ack_i  = 1'b1;
        mem_data_i = makeLine(32'hA000_0000, 32'hDEAD_BEEF);
        tick();
        mem_ack_i = 1'b0;
        checkOutput("refill_stall", {255'b0, cpu_stall_o}, 256'd0);
        checkOutput("refill_data",  {224'b0, cpu_data_o},  256'hDEAD_BEEF);
        checkOutput("refill_req",   {255'b0, mem_req_o},   256'd0);

        // Store hit then load hit on the same word.
        applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678);
        checkOutput("st_hit_stall", {255'b0, cpu_stall_o}, 256'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        checkOutput("ld_hit_stall", {255'b0, cpu_stall_o}, 256'd0);
        checkOutput("ld_hit_data",  {224'b0, cpu_data_o},  256'h1234_5678);
        checkOutput("ld_hit_req",   {255'b0, mem_req_o},   256'd0);
        tick();

        // Dirty miss: 0x240 maps to the same index with a new tag.
        applyStimulus(1'b1, 1'b0, 32'h0000_0240, 32'h0);
        checkOutput("dmiss_stall_c0", {255'b0, cpu_stall_o}, 256'd1);
        tick();
        wb_line = makeLine(32'hA000_0000, 32'hDEAD_BEEF);
        wb_line[63:32] = 32'h1234_5678;
        checkOutput("wb_req",   {255'b0, mem_req_o},  256'd1);
        checkOutput("wb_we",    {255'b0, mem_we_o},   256'd1);
        checkOutput("wb_addr",  {224'b0, mem_addr_o}, 256'h40);
        checkOutput("wb_mdata", mem_data_o,           wb_line);
        tick();
        mem_ack_i = 1'b1;
        checkOutput("wb_stall_ack", {255'b0, cpu_stall_o}, 256'd1);
        tick();
        mem_ack_i = 1'b0;
        checkOutput("alloc_req",   {255'b0, mem_req_o},   256'd1);
        checkOutput("alloc_we",    {255'b0, mem_we_o},    256'd0);
        checkOutput("alloc_addr",  {224'b0, mem_addr_o},  256'h240);
        checkOutput("alloc_stall", {255'b0, cpu_stall_o}, 256'd1);
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = makeLine(32'hB000_0000, 32'hB000_0000);
        checkOutput("alloc_stall_ack", {255'b0, cpu_stall_o}, 256'd1);
        tick();
        mem_ack_i = 1'b0;
        checkOutput("dmiss_done_stall", {255'b0, cpu_stall_o}, 256'd0);
        checkOutput("dmiss_done_data",  {224'b0, cpu_data_o},  256'hB000_0000);

        // Stray ack with req low must not change state.
        applyStimulus(1'b0, 1'b0, 32'h0000_0080, 32'h0);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        #1;
        checkOutput("stray_req",   {255'b0, mem_req_o},   256'd0);
        checkOutput("stray_stall", {255'b0, cpu_stall_o}, 256'd0);

        // Ack in the first cycle of req: hit two cycles after the miss cycle.
        applyStimulus(1'b1, 1'b0, 32'h0000_0084, 32'h0);
        checkOutput("fast_stall_c0", {255'b0, cpu_stall_o}, 256'd1);
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = makeLine(32'hC000_0000, 32'hC000_0000);
        checkOutput("fast_addr", {224'b0, mem_addr_o}, 256'h80);
        tick();
        mem_ack_i = 1'b0;
        checkOutput("fast_stall_c2", {255'b0, cpu_stall_o}, 256'd0);
        checkOutput("fast_data_c2",  {224'b0, cpu_data_o},  256'hC000_0001);

        // Make index 4 dirty, then reset in the middle of an ALLOCATE.
        applyStimulus(1'b0, 1'b1, 32'h0000_0084, 32'h5555_AAAA);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        tick();
        checkOutput("pre_rst_req", {255'b0, mem_req_o}, 256'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checkOutput("rst_mid_req",   {255'b0, mem_req_o},   256'd0);
        checkOutput("rst_mid_addr",  {224'b0, mem_addr_o},  256'd0);
        checkOutput("rst_mid_remiss", {255'b0, cpu_stall_o}, 256'd1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0240, 32'h0);
        checkOutput("rst_inval_240", {255'b0, cpu_stall_o}, 256'd1);

        // Store miss to index 4 after reset: dirty was cleared, so no write-back.
        applyStimulus(1'b0, 1'b1, 32'h0000_0284, 32'h7777_0001);
        tick();
        checkOutput("stmiss_we",   {255'b0, mem_we_o},   256'd0);
        checkOutput("stmiss_addr", {224'b0, mem_addr_o}, 256'h280);
        mem_ack_i  = 1'b1;
        mem_data_i = makeLine(32'hD000_0000, 32'hD000_0000);
        tick();
        mem_ack_i = 1'b0;
        checkOutput("stmiss_hit_stall", {255'b0, cpu_stall_o}, 256'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0284, 32'h0);
        checkOutput("stmiss_ld_data", {224'b0, cpu_data_o}, 256'h7777_0001);
        tick();

        // Conflicting load at 0x80 must write back the stored line.
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'h0);
        tick();
        wb_line = makeLine(32'hD000_0000, 32'hD000_0000);
        wb_line[63:32] = 32'h7777_0001;
        checkOutput("wb2_we",    {255'b0, mem_we_o},   256'd1);
        checkOutput("wb2_addr",  {224'b0, mem_addr_o}, 256'h280);
        checkOutput("wb2_mdata", mem_data_o,           wb_line);
        mem_ack_i = 1'b1;
        tick();
        mem_data_i = makeLine(32'hE000_0000, 32'hE000_0000);
        tick();
        mem_ack_i = 1'b0;
        checkOutput("wb2_done_stall", {255'b0, cpu_stall_o}, 256'd0);
        checkOutput("wb2_done_data",  {224'b0, cpu_data_o},  256'hE000_0000);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
